// File: rtl/axi_rd_arbiter.sv
// Two-port (fetch/load) read arbiter driving a single AXI4 AR/R channel.
// One single-beat transaction in flight; a streak counter keeps fetch from starving.
module axi_rd_arbiter #(
    parameter int ADDR_W          = 64,
    parameter int DATA_W          = 64,
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic              clk,
    input  logic              rstn,

    input  logic              if_req_valid,
    output logic              if_req_ready,
    input  logic [ADDR_W-1:0] if_req_addr,
    output logic              if_rsp_valid,
    output logic              if_rsp_err,

    input  logic              mm_req_valid,
    output logic              mm_req_ready,
    input  logic [ADDR_W-1:0] mm_req_addr,
    input  logic [2:0]        mm_req_size,
    output logic              mm_rsp_valid,
    output logic              mm_rsp_err,

    output logic [DATA_W-1:0] rsp_data,

    output logic [3:0]        ARID,
    output logic [ADDR_W-1:0] ARADDR,
    output logic [7:0]        ARLEN,
    output logic [2:0]        ARSIZE,
    output logic [1:0]        ARBURST,
    output logic [2:0]        ARPROT,
    output logic              ARVALID,
    input  logic              ARREADY,

    input  logic [3:0]        RID,
    input  logic [DATA_W-1:0] RDATA,
    input  logic [1:0]        RRESP,
    input  logic              RLAST,
    input  logic              RVALID,
    output logic              RREADY,

    output logic [1:0]        dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2
    } state_t;

    localparam logic [2:0] MAX_STREAK = 3'(MAX_DATA_STREAK);

    state_t              state_q, state_d;
    logic [2:0]          streak_q, streak_d;
    logic [3:0]          arid_q, arid_d;
    logic [ADDR_W-1:0]   araddr_q, araddr_d;
    logic [2:0]          arsize_q, arsize_d;
    logic [1:0]          arburst_q, arburst_d;
    logic [2:0]          arprot_q, arprot_d;
    logic                err_flag_q, err_flag_d;
    logic                if_rsp_valid_q, if_rsp_valid_d;
    logic                mm_rsp_valid_q, mm_rsp_valid_d;
    logic                if_rsp_err_q, if_rsp_err_d;
    logic                mm_rsp_err_q, mm_rsp_err_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;

    logic contested;
    logic if_win;
    logic mm_win;
    logic beat_err;

    // Fetch wins when alone, or when loads have used up their contested streak.
    assign contested = if_req_valid && mm_req_valid;
    assign if_win    = if_req_valid && (!mm_req_valid || (streak_q == MAX_STREAK));
    assign mm_win    = mm_req_valid && !if_win;
    assign beat_err  = (RRESP != 2'b00) || (RID != arid_q) || err_flag_q;

    always_comb begin
        state_d        = state_q;
        streak_d       = streak_q;
        arid_d         = arid_q;
        araddr_d       = araddr_q;
        arsize_d       = arsize_q;
        arburst_d      = arburst_q;
        arprot_d       = arprot_q;
        err_flag_d     = err_flag_q;
        if_rsp_valid_d = 1'b0;
        mm_rsp_valid_d = 1'b0;
        if_rsp_err_d   = 1'b0;
        mm_rsp_err_d   = 1'b0;
        rsp_data_d     = rsp_data_q;
        if_req_ready   = 1'b0;
        mm_req_ready   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (if_win || mm_win) begin
                    if_req_ready = if_win;
                    mm_req_ready = mm_win;
                    state_d      = S_ADDR;
                    err_flag_d   = 1'b0;
                    arburst_d    = 2'b01;
                    if (if_win) begin
                        arid_d   = 4'd0;
                        araddr_d = if_req_addr;
                        arsize_d = 3'b010;
                        arprot_d = 3'b100;
                        streak_d = 3'd0;
                    end else begin
                        arid_d   = 4'd1;
                        araddr_d = mm_req_addr;
                        arsize_d = mm_req_size;
                        arprot_d = 3'b000;
                        streak_d = contested ? (streak_q + 3'd1) : 3'd0;
                    end
                end
            end
            S_ADDR: begin
                if (ARREADY) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (RVALID) begin
                    if (RLAST) begin
                        rsp_data_d = RDATA;
                        state_d    = S_IDLE;
                        // arid_q[0] identifies the owner: 0 = fetch, 1 = load.
                        if (arid_q[0]) begin
                            mm_rsp_valid_d = 1'b1;
                            mm_rsp_err_d   = beat_err;
                        end else begin
                            if_rsp_valid_d = 1'b1;
                            if_rsp_err_d   = beat_err;
                        end
                    end else begin
                        err_flag_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q        <= S_IDLE;
            streak_q       <= 3'd0;
            arid_q         <= 4'd0;
            araddr_q       <= '0;
            arsize_q       <= 3'd0;
            arburst_q      <= 2'd0;
            arprot_q       <= 3'd0;
            err_flag_q     <= 1'b0;
            if_rsp_valid_q <= 1'b0;
            mm_rsp_valid_q <= 1'b0;
            if_rsp_err_q   <= 1'b0;
            mm_rsp_err_q   <= 1'b0;
            rsp_data_q     <= '0;
        end else begin
            state_q        <= state_d;
            streak_q       <= streak_d;
            arid_q         <= arid_d;
            araddr_q       <= araddr_d;
            arsize_q       <= arsize_d;
            arburst_q      <= arburst_d;
            arprot_q       <= arprot_d;
            err_flag_q     <= err_flag_d;
            if_rsp_valid_q <= if_rsp_valid_d;
            mm_rsp_valid_q <= mm_rsp_valid_d;
            if_rsp_err_q   <= if_rsp_err_d;
            mm_rsp_err_q   <= mm_rsp_err_d;
            rsp_data_q     <= rsp_data_d;
        end
    end

    assign ARVALID      = (state_q == S_ADDR);
    assign RREADY       = (state_q == S_DATA);
    assign ARID         = arid_q;
    assign ARADDR       = araddr_q;
    assign ARLEN        = 8'd0;
    assign ARSIZE       = arsize_q;
    assign ARBURST      = arburst_q;
    assign ARPROT       = arprot_q;
    assign if_rsp_valid = if_rsp_valid_q;
    assign mm_rsp_valid = mm_rsp_valid_q;
    assign if_rsp_err   = if_rsp_err_q;
    assign mm_rsp_err   = mm_rsp_err_q;
    assign rsp_data     = rsp_data_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter: grant order, AR fields, R steering, errors and reset.
// Responses are predicted into exp_q when R beats are driven and popped by the monitor.
module tb_axi_rd_arbiter;

    localparam int ADDR_W = 64;
    localparam int DATA_W = 64;
    localparam int W      = 2 + DATA_W;

    logic              clk;
    logic              rstn;
    logic              if_req_valid, if_req_ready, if_rsp_valid, if_rsp_err;
    logic [ADDR_W-1:0] if_req_addr;
    logic              mm_req_valid, mm_req_ready, mm_rsp_valid, mm_rsp_err;
    logic [ADDR_W-1:0] mm_req_addr;
    logic [2:0]        mm_req_size;
    logic [DATA_W-1:0] rsp_data;
    logic [3:0]        ARID;
    logic [ADDR_W-1:0] ARADDR;
    logic [7:0]        ARLEN;
    logic [2:0]        ARSIZE;
    logic [1:0]        ARBURST;
    logic [2:0]        ARPROT;
    logic              ARVALID, ARREADY;
    logic [3:0]        RID;
    logic [DATA_W-1:0] RDATA;
    logic [1:0]        RRESP;
    logic              RLAST, RVALID, RREADY;
    logic [1:0]        dbg_state_o;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0]      exp_q[$];
    logic [3:0]        cur_id;
    logic [ADDR_W-1:0] cur_addr;
    logic [2:0]        cur_size;
    logic [2:0]        cur_prot;
    logic              nonlast_seen;

    axi_rd_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_DATA_STREAK(4)) dut (
        .clk(clk), .rstn(rstn),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
        .if_rsp_valid(if_rsp_valid), .if_rsp_err(if_rsp_err),
        .mm_req_valid(mm_req_valid), .mm_req_ready(mm_req_ready), .mm_req_addr(mm_req_addr),
        .mm_req_size(mm_req_size), .mm_rsp_valid(mm_rsp_valid), .mm_rsp_err(mm_rsp_err),
        .rsp_data(rsp_data),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
        .dbg_state_o(dbg_state_o)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Present requests in IDLE, check the grant, then check the AR fields one cycle later.
    task automatic grant(input logic vi, input logic vm, input logic exp_mm,
                         input logic keep_i, input logic keep_m);
        if_req_valid = vi;
        mm_req_valid = vm;
        #1;
        chk("idle_state", dbg_state_o, 2'd0);
        chk("if_ready", if_req_ready, !exp_mm);
        chk("mm_ready", mm_req_ready, exp_mm);
        cur_id       = exp_mm ? 4'd1 : 4'd0;
        cur_addr     = exp_mm ? mm_req_addr : if_req_addr;
        cur_size     = exp_mm ? mm_req_size : 3'b010;
        cur_prot     = exp_mm ? 3'b000 : 3'b100;
        nonlast_seen = 1'b0;
        tick();
        if_req_valid = keep_i;
        mm_req_valid = keep_m;
        chk("arvalid_t1", ARVALID, 1'b1);
        chk("arid", ARID, cur_id);
        chk("araddr", ARADDR, cur_addr);
        chk("arsize", ARSIZE, cur_size);
        chk("arprot", ARPROT, cur_prot);
        chk("arlen", ARLEN, 8'd0);
        chk("arburst", ARBURST, 2'b01);
        chk("rready_addr", RREADY, 1'b0);
        chk("ready_busy", {if_req_ready, mm_req_ready}, 2'b00);
    endtask

    task automatic ar_hs(input int stall);
        for (int i = 0; i < stall; i++) begin
            ARREADY = 1'b0;
            tick();
            chk("arvalid_hold", ARVALID, 1'b1);
            chk("arid_hold", ARID, cur_id);
            chk("araddr_hold", ARADDR, cur_addr);
            chk("arsize_hold", ARSIZE, cur_size);
            chk("arprot_hold", ARPROT, cur_prot);
            chk("rready_hold", RREADY, 1'b0);
        end
        ARREADY = 1'b1;
        tick();
        ARREADY = 1'b0;
        chk("arvalid_drop", ARVALID, 1'b0);
        chk("rready_data", RREADY, 1'b1);
    endtask

    task automatic r_beat(input logic [3:0] id, input logic [DATA_W-1:0] data,
                          input logic [1:0] resp, input logic last);
        logic err;
        RVALID = 1'b1;
        RID    = id;
        RDATA  = data;
        RRESP  = resp;
        RLAST  = last;
        if (last) begin
            err = (resp != 2'b00) || (id != cur_id) || nonlast_seen;
            exp_q.push_back({cur_id[0], err, data});
            nonlast_seen = 1'b0;
        end else begin
            nonlast_seen = 1'b1;
        end
        tick();
        RVALID = 1'b0;
        RLAST  = 1'b0;
        if (last) begin
            chk("back_idle", dbg_state_o, 2'd0);
            chk("rready_idle", RREADY, 1'b0);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (if_req_ready && mm_req_ready) chk("ready_both", 1'b1, 1'b0);
        if (if_rsp_valid || mm_rsp_valid) begin
            if (exp_q.size() == 0) begin
                chk("rsp_unexpected", {if_rsp_valid, mm_rsp_valid}, 2'b00);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_both", {if_rsp_valid, mm_rsp_valid}, e[W-1] ? 2'b01 : 2'b10);
                chk("rsp_err", e[W-1] ? mm_rsp_err : if_rsp_err, e[W-2]);
                chk("rsp_data", rsp_data, e[DATA_W-1:0]);
            end
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        rstn = 1'b0;
        if_req_valid = 1'b0; if_req_addr = '0;
        mm_req_valid = 1'b0; mm_req_addr = '0; mm_req_size = 3'd0;
        ARREADY = 1'b0; RID = 4'd0; RDATA = '0; RRESP = 2'd0; RLAST = 1'b0; RVALID = 1'b0;
        nonlast_seen = 1'b0;
        cur_id = 4'd0; cur_addr = '0; cur_size = 3'd0; cur_prot = 3'd0;
        repeat (3) tick();
        rstn = 1'b1;

        // Reset values
        chk("rst_state", dbg_state_o, 2'd0);
        chk("rst_arvalid", ARVALID, 1'b0);
        chk("rst_rready", RREADY, 1'b0);
        chk("rst_ar_fields", {ARID, ARLEN, ARSIZE, ARBURST, ARPROT}, 20'd0);
        chk("rst_araddr", ARADDR, 64'd0);
        chk("rst_rsp", {if_rsp_valid, if_rsp_err, mm_rsp_valid, mm_rsp_err}, 4'd0);
        chk("rst_rsp_data", rsp_data, 64'd0);
        chk("rst_ready", {if_req_ready, mm_req_ready}, 2'b00);

        // Single fetch
        if_req_addr = 64'h8000_0000;
        grant(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        ar_hs(0);
        r_beat(4'd0, 64'h13, 2'b00, 1'b1);

        // Contested once: load first, fetch in the IDLE cycle after the load response
        if_req_addr = {32'h0, $urandom};
        mm_req_addr = {$urandom, $urandom};
        mm_req_size = 3'd3;
        grant(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        ar_hs(0);
        r_beat(4'd1, {$urandom, $urandom}, 2'b00, 1'b1);
        grant(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        ar_hs(0);
        r_beat(4'd0, {$urandom, $urandom}, 2'b00, 1'b1);

        // Starvation guard: mm,mm,mm,mm,if,mm with both held valid
        for (int i = 0; i < 6; i++) begin
            logic want_mm;
            want_mm = (i != 4);
            mm_req_size = 3'($urandom_range(0, 3));
            grant(1'b1, 1'b1, want_mm, 1'b1, 1'b1);
            ar_hs(0);
            r_beat(want_mm ? 4'd1 : 4'd0, {$urandom, $urandom}, 2'b00, 1'b1);
        end
        if_req_valid = 1'b0;
        mm_req_valid = 1'b0;

        // Held AR for 5 cycles
        if_req_addr = {$urandom, $urandom};
        grant(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        ar_hs(5);
        r_beat(4'd0, {$urandom, $urandom}, 2'b00, 1'b1);

        // Error cases: SLVERR, RID mismatch, extra non-last beat
        mm_req_addr = {$urandom, $urandom};
        grant(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        ar_hs(1);
        r_beat(4'd1, {$urandom, $urandom}, 2'b10, 1'b1);
        grant(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        ar_hs(0);
        r_beat(4'd1, {$urandom, $urandom}, 2'b00, 1'b1);
        grant(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        ar_hs(0);
        r_beat(4'd1, {$urandom, $urandom}, 2'b00, 1'b0);
        r_beat(4'd1, {$urandom, $urandom}, 2'b00, 1'b1);

        // Reset while in DATA with a final beat on the bus: no response may appear
        if_req_addr = 64'h8000_0100;
        grant(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        ar_hs(0);
        rstn = 1'b0;
        RVALID = 1'b1; RLAST = 1'b1; RID = 4'd0; RRESP = 2'b00; RDATA = 64'hdead;
        tick();
        rstn = 1'b1;
        RVALID = 1'b0; RLAST = 1'b0;
        nonlast_seen = 1'b0;
        chk("rstmid_arvalid", ARVALID, 1'b0);
        chk("rstmid_rready", RREADY, 1'b0);
        chk("rstmid_state", dbg_state_o, 2'd0);
        chk("rstmid_rsp", {if_rsp_valid, mm_rsp_valid}, 2'b00);
        tick();
        chk("rstmid_rsp_next", {if_rsp_valid, mm_rsp_valid}, 2'b00);

        // Fresh fetch after reset
        if_req_addr = 64'h8000_0200;
        grant(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        ar_hs(0);
        r_beat(4'd0, 64'h1234_5678_9abc_def0, 2'b00, 1'b1);

        repeat (3) tick();
        chk("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
